// File: rtl/iterative_alu.sv
// Multi-cycle ALU with a start/busy/done handshake: one-bit-per-cycle shifts and rotates,
// plus an optional shift-add multiplier enabled by defining ALU_MUL_EN.
module iterative_alu #(
  parameter int unsigned Width = 32,
  localparam int unsigned ShW = $clog2(Width) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [4:0]       fun_sel_i,
  input  logic [ShW-1:0]   sh_amt_i,
  input  logic             wf_i,
  output logic [Width-1:0] alu_out_o,
  output logic [3:0]       flags_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             illegal_op_o
);

  localparam logic [4:0] OpMovA = 5'b00000;
  localparam logic [4:0] OpMovB = 5'b00001;
  localparam logic [4:0] OpNotA = 5'b00010;
  localparam logic [4:0] OpNotB = 5'b00011;
  localparam logic [4:0] OpAdd  = 5'b00100;
  localparam logic [4:0] OpAdc  = 5'b00101;
  localparam logic [4:0] OpSub  = 5'b00110;
  localparam logic [4:0] OpAnd  = 5'b00111;
  localparam logic [4:0] OpOr   = 5'b01000;
  localparam logic [4:0] OpXor  = 5'b01001;
  localparam logic [4:0] OpNand = 5'b01010;
  localparam logic [4:0] OpLsl  = 5'b01011;
  localparam logic [4:0] OpLsr  = 5'b01100;
  localparam logic [4:0] OpAsr  = 5'b01101;
  localparam logic [4:0] OpCsl  = 5'b01110;
  localparam logic [4:0] OpCsr  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] a_q, b_q, work_q, work_d, alu_out_q;
  logic [4:0]       op_q;
  logic             wf_q, cin_q, wc_q, wc_d;
  logic [ShW-1:0]   cnt_q, cnt_d;
  logic [3:0]       flags_q;
  logic             done_q, illegal_q;

  logic             accept, is_shift, is_mul, last_c, run_last, legal_c;
  logic [Width-1:0] add_b, sh_w, res_c;
  logic [Width:0]   add_c;
  logic             add_ovf, sh_c, c_n, o_n;

`ifdef ALU_MUL_EN
  logic [Width-1:0] hi_q, hi_d, mul_hi_n, mul_lo_n;
  logic [Width:0]   mul_sum;
  assign is_mul   = (op_q == OpMul);
  assign mul_sum  = {1'b0, hi_q} + {1'b0, (work_q[0] ? a_q : '0)};
  assign mul_hi_n = mul_sum[Width:1];
  assign mul_lo_n = {mul_sum[0], work_q[Width-1:1]};
`else
  assign is_mul   = 1'b0;
`endif

  assign accept   = start_i && (state_q == StIdle);
  assign is_shift = (op_q >= OpLsl) && (op_q <= OpCsr);
  assign last_c   = is_shift ? (cnt_q <= ShW'(1)) : (is_mul ? (cnt_q == ShW'(1)) : 1'b1);
  assign run_last = (state_q == StRun) && last_c;

  // Subtract shares the adder: A + ~B + 1, so overflow uses the effective B operand.
  assign add_b   = (op_q == OpSub) ? ~b_q : b_q;
  assign add_c   = {1'b0, a_q} + {1'b0, add_b}
                 + {{Width{1'b0}}, (op_q == OpSub) | ((op_q == OpAdc) & cin_q)};
  assign add_ovf = (a_q[Width-1] == add_b[Width-1]) && (add_c[Width-1] != a_q[Width-1]);

  always_comb begin
    sh_w = work_q;
    sh_c = wc_q;
    case (op_q)
      OpLsl:   begin sh_w = {work_q[Width-2:0], 1'b0};         sh_c = work_q[Width-1]; end
      OpLsr:   begin sh_w = {1'b0, work_q[Width-1:1]};         sh_c = work_q[0];       end
      OpAsr:   begin sh_w = {work_q[Width-1], work_q[Width-1:1]}; sh_c = work_q[0];    end
      OpCsl:   begin sh_w = {work_q[Width-2:0], wc_q};         sh_c = work_q[Width-1]; end
      OpCsr:   begin sh_w = {wc_q, work_q[Width-1:1]};         sh_c = work_q[0];       end
      default: ;
    endcase
  end

  // Result and flag candidates for the completing cycle.
  always_comb begin
    res_c   = alu_out_q;
    c_n     = flags_q[2];
    o_n     = flags_q[0];
    legal_c = 1'b1;
    case (op_q)
      OpMovA: res_c = a_q;
      OpMovB: res_c = b_q;
      OpNotA: res_c = ~a_q;
      OpNotB: res_c = ~b_q;
      OpAdd, OpAdc, OpSub: begin
        res_c = add_c[Width-1:0];
        c_n   = add_c[Width];
        o_n   = add_ovf;
      end
      OpAnd:  res_c = a_q & b_q;
      OpOr:   res_c = a_q | b_q;
      OpXor:  res_c = a_q ^ b_q;
      OpNand: res_c = ~(a_q & b_q);
      OpLsl, OpLsr, OpAsr, OpCsl, OpCsr: begin
        res_c = (cnt_q != '0) ? sh_w : work_q;
        c_n   = (cnt_q != '0) ? sh_c : wc_q;
      end
`ifdef ALU_MUL_EN
      OpMul: begin
        res_c = mul_lo_n;
        c_n   = |mul_hi_n;
      end
`endif
      default: legal_c = 1'b0;
    endcase
  end

  always_comb begin
    work_d = work_q;
    wc_d   = wc_q;
    cnt_d  = cnt_q;
`ifdef ALU_MUL_EN
    hi_d   = hi_q;
`endif
    if (accept) begin
      work_d = a_i;
      wc_d   = flags_q[2];
      cnt_d  = sh_amt_i;
`ifdef ALU_MUL_EN
      hi_d   = '0;
      if (fun_sel_i == OpMul) begin
        work_d = b_i;
        cnt_d  = ShW'(Width);
      end
`endif
    end else if (state_q == StRun && !last_c) begin
      cnt_d = cnt_q - ShW'(1);
      if (is_shift) begin
        work_d = sh_w;
        wc_d   = sh_c;
      end
`ifdef ALU_MUL_EN
      if (is_mul) begin
        work_d = mul_lo_n;
        hi_d   = mul_hi_n;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRun;
      StRun:  if (last_c) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == StRun);
    done_o       = done_q;
    illegal_op_o = illegal_q;
    alu_out_o    = alu_out_q;
    flags_out_o  = flags_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      wf_q      <= 1'b0;
      cin_q     <= 1'b0;
      work_q    <= '0;
      wc_q      <= 1'b0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q      <= '0;
`endif
    end else begin
      if (accept) begin
        a_q   <= a_i;
        b_q   <= b_i;
        op_q  <= fun_sel_i;
        wf_q  <= wf_i;
        cin_q <= flags_q[2];
      end
      work_q <= work_d;
      wc_q   <= wc_d;
      cnt_q  <= cnt_d;
`ifdef ALU_MUL_EN
      hi_q   <= hi_d;
`endif
      if (run_last && legal_c) begin
        alu_out_q <= res_c;
        if (wf_q) flags_q <= {res_c == '0, c_n, res_c[Width-1], o_n};
      end
      done_q    <= run_last;
      illegal_q <= run_last && !legal_c;
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu at Width=32; MUL expectations follow ALU_MUL_EN.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        rst, start, wf;
  logic [31:0] a, b;
  logic [4:0]  fun;
  logic [5:0]  sh;
  logic [31:0] alu_out;
  logic [3:0]  flags;
  logic        busy, done, illegal;

  int n_checks = 0;
  int n_errors = 0;

  iterative_alu #(.Width(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .a_i         (a),
    .b_i         (b),
    .fun_sel_i   (fun),
    .sh_amt_i    (sh),
    .wf_i        (wf),
    .alu_out_o   (alu_out),
    .flags_out_o (flags),
    .busy_o      (busy),
    .done_o      (done),
    .illegal_op_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one op; poke raises Start again mid-run with different operands.
  task automatic do_op(input logic [4:0] f, input logic [31:0] av, input logic [31:0] bv,
                       input logic [5:0] s, input logic w, input bit poke, output int cyc);
    @(negedge clk);
    fun = f; a = av; b = bv; sh = s; wf = w; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 2) begin
        start = 1'b1; fun = 5'b00001; b = 32'hDEADBEEF;
      end
      if (poke && cyc == 3) start = 1'b0;
    end
  endtask

  task automatic op_chk(input string tag, input logic [4:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [5:0] s, input logic w, input bit poke,
                        input int exp_cyc, input logic [31:0] exp_out, input logic [3:0] exp_fl,
                        input logic exp_ill);
    int cyc;
    do_op(f, av, bv, s, w, poke, cyc);
    check_eq({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
    check_eq({tag, "_out"}, 64'(alu_out), 64'(exp_out));
    check_eq({tag, "_flags"}, 64'(flags), 64'(exp_fl));
    check_eq({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; wf = 1'b0; a = '0; b = '0; fun = '0; sh = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out", 64'(alu_out), 64'h0);
    check_eq("rst_flags", 64'(flags), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    check_eq("rst_ill", 64'(illegal), 64'h0);
    @(negedge clk) rst = 1'b0;

    // Flags are {Z, C, N, O}.
    op_chk("add_ovf", 5'b00100, 32'h7FFFFFFF, 32'h1, 6'd0, 1'b1, 1'b0, 1, 32'h80000000, 4'b0011, 1'b0);
    op_chk("add_carry", 5'b00100, 32'hFFFFFFFF, 32'h1, 6'd0, 1'b1, 1'b0, 1, 32'h0, 4'b1100, 1'b0);
    op_chk("adc", 5'b00101, 32'h1, 32'h2, 6'd0, 1'b1, 1'b0, 1, 32'h4, 4'b0000, 1'b0);
    op_chk("asr4", 5'b01101, 32'h80000010, 32'h0, 6'd4, 1'b1, 1'b1, 4, 32'hF8000001, 4'b0010, 1'b0);
    check_eq("asr_no_restart", 64'(busy), 64'h0);
    op_chk("set_c", 5'b00100, 32'hFFFFFFFF, 32'h1, 6'd0, 1'b1, 1'b0, 1, 32'h0, 4'b1100, 1'b0);
    op_chk("csr1", 5'b01111, 32'h1, 32'h0, 6'd1, 1'b1, 1'b0, 1, 32'h80000000, 4'b0110, 1'b0);

    // LSL by 10 aborted by reset in RUN cycle 5; a concurrent Start must lose to reset.
    @(negedge clk);
    fun = 5'b01011; a = 32'h1; sh = 6'd10; wf = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; fun = 5'b00000; a = 32'hABC;
    @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(seen), 64'h0);
    check_eq("abort_done", 64'(done), 64'h0);
    check_eq("abort_busy", 64'(busy), 64'h0);
    check_eq("abort_out", 64'(alu_out), 64'h0);
    check_eq("abort_flags", 64'(flags), 64'h0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    op_chk("mova", 5'b00000, 32'h1234, 32'h0, 6'd0, 1'b1, 1'b0, 1, 32'h1234, 4'b0000, 1'b0);
    op_chk("lsl32", 5'b01011, 32'h1, 32'h0, 6'd32, 1'b1, 1'b0, 32, 32'h0, 4'b1100, 1'b0);
    op_chk("csl33", 5'b01110, 32'h12345678, 32'h0, 6'd33, 1'b1, 1'b0, 33, 32'h12345678, 4'b0100,
           1'b0);
    op_chk("lsr0", 5'b01100, 32'h3, 32'h0, 6'd0, 1'b1, 1'b0, 1, 32'h3, 4'b0100, 1'b0);
    op_chk("xor", 5'b01001, 32'hF0F0F0F0, 32'hFF00FF00, 6'd0, 1'b1, 1'b0, 1, 32'h0FF00FF0, 4'b0100,
           1'b0);
    op_chk("add_ovf2", 5'b00100, 32'h7FFFFFFF, 32'h1, 6'd0, 1'b1, 1'b0, 1, 32'h80000000, 4'b0011,
           1'b0);
    op_chk("sub_nowf", 5'b00110, 32'h5, 32'h5, 6'd0, 1'b0, 1'b0, 1, 32'h0, 4'b0011, 1'b0);
    op_chk("illegal", 5'b10011, 32'h77, 32'h88, 6'd0, 1'b1, 1'b0, 1, 32'h0, 4'b0011, 1'b1);
`ifdef ALU_MUL_EN
    op_chk("mul", 5'b10000, 32'h00010000, 32'h00010000, 6'd0, 1'b1, 1'b0, 32, 32'h0, 4'b1101,
           1'b0);
    op_chk("mul_small", 5'b10000, 32'd1234, 32'd5678, 6'd0, 1'b1, 1'b0, 32, 32'd7006652, 4'b0001,
           1'b0);
`else
    op_chk("mul_ill", 5'b10000, 32'h00010000, 32'h00010000, 6'd0, 1'b1, 1'b0, 1, 32'h0, 4'b0011,
           1'b1);
`endif
    op_chk("sub", 5'b00110, 32'h3, 32'h5, 6'd0, 1'b1, 1'b0, 1, 32'hFFFFFFFE, 4'b0010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
